sevenseg_driver: RTL and testbench

Output-side user-interface block: it drives a 4-digit, common-anode, multiplexed seven-segment display from a 16-bit hex value. It sits between the processor's memory-mapped I/O and the board pins, alongside the input-side button debouncer. It scans one digit at a time with anti-ghosting guard time, per-digit blanking/blinking and decimal points. New values are latched at any time but applied only at a frame boundary, so a displayed frame never tears.

---
 rtl/sevenseg_driver.sv | 128 ++++++++++++
 tb/tb_sevenseg_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_driver.sv
// sevenseg_driver: scans a 4-digit common-anode seven-segment display from a
// 16-bit hex value. New values are captured into a shadow set on load and
// moved to the display set only at a frame boundary, so a frame never tears.
// A short guard at the start of every digit dwell keeps all anodes off while
// the cathodes change, which prevents ghosting between neighbouring digits.
module sevenseg_driver #(
  parameter int REFRESH_BITS = 16,
  parameter int GUARD        = 4,
  parameter int BLINK_BITS   = 24
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  blink_in,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } digit_set_t;

  localparam logic [REFRESH_BITS-1:0] GUARD_CNT = REFRESH_BITS'(GUARD);

  digit_set_t              shadow_q, display_q;
  logic                    pending_q;
  logic [REFRESH_BITS-1:0] rcnt_q;
  logic [1:0]              idx_q;
  logic [BLINK_BITS-1:0]   bcnt_q;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    dwell_end;
  logic                    frame_end;
  logic                    dark;
  logic [3:0]              nibble;
  digit_set_t              load_set;

  assign dwell_end = &rcnt_q;
  assign frame_end = dwell_end && (idx_q == 2'd3);
  assign load_set  = '{data: data_in, dp: dp_in, blank: blank_in, blink: blink_in};

  // Next output values for the digit currently selected by idx_q.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    seg_d  = 7'h7F;
    nibble = display_q.data[{idx_q, 2'b00} +: 4];
    dark   = (rcnt_q < GUARD_CNT)
          || display_q.blank[idx_q]
          || (display_q.blink[idx_q] && bcnt_q[BLINK_BITS-1]);

    unique case (nibble)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'h7F;
    endcase

    an_d = ~(4'b0001 << idx_q);
    dp_d = ~display_q.dp[idx_q];
    if (dark) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // Scan counters, shadow/display transfer and registered pin outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      rcnt_q    <= '0;
      idx_q     <= 2'd0;
      bcnt_q    <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      rcnt_q <= rcnt_q + REFRESH_BITS'(1);
      bcnt_q <= bcnt_q + BLINK_BITS'(1);
      if (dwell_end) idx_q <= idx_q + 2'd1;

      // NOTE: non-blocking assignment makes display_q take the pre-load
      // shadow when a load lands on the same edge as the frame boundary.
      if (frame_end) display_q <= shadow_q;
      if (load) begin
        shadow_q  <= load_set;
        pending_q <= 1'b1;
      end else if (frame_end) begin
        pending_q <= 1'b0;
      end

      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign pending = pending_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_sevenseg_driver.sv
// tb_sevenseg_driver: table-driven digit checks, hand-written boundary/reset
// sequences and randomized loads, all compared against a cycle-count model.
module tb_sevenseg_driver;

  localparam int REFRESH_BITS = 3;
  localparam int GUARD        = 2;
  localparam int BLINK_BITS   = 6;
  localparam int DWELL        = 1 << REFRESH_BITS;
  localparam int FRAME        = 4 * DWELL;
  localparam int BPERIOD      = 1 << BLINK_BITS;

  logic        CLK = 1'b0;
  logic        rst, load;
  logic [15:0] data_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  sevenseg_driver #(
    .REFRESH_BITS(REFRESH_BITS),
    .GUARD       (GUARD),
    .BLINK_BITS  (BLINK_BITS)
  ) dut (
    .CLK     (CLK),
    .rst     (rst),
    .load    (load),
    .data_in (data_in),
    .dp_in   (dp_in),
    .blank_in(blank_in),
    .blink_in(blink_in),
    .pending (pending),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } set_t;

  typedef struct packed {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0]       blank;
    logic [3:0][6:0]  seg;   // expected cathodes per digit when lit
    logic [3:0]       dpo;   // expected dp pin per digit when lit
    logic [3:0]       dark;  // digits expected fully dark
  } vec_t;

  logic [6:0] hex_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counter values follow from cycles since reset.
  int         t;
  set_t       m_shadow, m_disp;
  logic       m_pend;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // One clock: capture the applied inputs, advance the model, compare.
  task automatic step();
    logic        l_rst, l_load;
    set_t        l_set;
    int          r, i, b;
    logic        drk;
    l_rst  = rst;
    l_load = load;
    l_set  = '{data: data_in, dp: dp_in, blank: blank_in, blink: blink_in};
    @(posedge CLK);
    #1;
    if (l_rst) begin
      t = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      r = t % DWELL;
      i = (t / DWELL) % 4;
      b = t % BPERIOD;
      drk = (r < GUARD) || m_disp.blank[i] || (m_disp.blink[i] && b >= BPERIOD / 2);
      if (drk) begin
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_an  = 4'hF & ~(4'(1) << i);
        m_seg = hex_lut[m_disp.data[i*4 +: 4]];
        m_dp  = ~m_disp.dp[i];
      end
      if (t % FRAME == FRAME - 1) m_disp = m_shadow;
      if (l_load) begin
        m_shadow = l_set;
        m_pend   = 1'b1;
      end else if (t % FRAME == FRAME - 1) begin
        m_pend = 1'b0;
      end
      t++;
    end
    check("an", 32'(an), 32'(m_an));
    check("seg", 32'(seg), 32'(m_seg));
    check("dp", 32'(dp), 32'(m_dp));
    check("pending", 32'(pending), 32'(m_pend));
    check("one_anode", 32'($countones(~an) <= 1), 32'(1));
  endtask

  // Step until the model's frame phase equals ph, bounded to two frames.
  task automatic run_until(input int ph);
    int n;
    n = 0;
    while ((t % FRAME) != ph && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("run_until_bound", 32'((t % FRAME) == ph), 32'(1));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                         input logic [3:0] bk);
    data_in = d; dp_in = p; blank_in = bl; blink_in = bk; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{data: 16'h1A2F, dp: 4'b0100, blank: 4'b0000,
                seg: {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110},
                dpo: 4'b1011, dark: 4'b0000};
    vecs[1] = '{data: 16'h0123, dp: 4'b1000, blank: 4'b1000,
                seg: {7'h7F, 7'b1111001, 7'b0100100, 7'b0110000},
                dpo: 4'b1111, dark: 4'b1000};
    vecs[2] = '{data: 16'h8888, dp: 4'b1111, blank: 4'b0000,
                seg: {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000},
                dpo: 4'b0000, dark: 4'b0000};
    vecs[3] = '{data: 16'hBCDE, dp: 4'b0001, blank: 4'b0000,
                seg: {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110},
                dpo: 4'b1110, dark: 4'b0000};
    vecs[4] = '{data: 16'h4567, dp: 4'b0000, blank: 4'b0101,
                seg: {7'b0011001, 7'h7F, 7'b0000010, 7'h7F},
                dpo: 4'b1111, dark: 4'b0101};

    t = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;
    step();
    step();
    rst = 1'b0;

    // Reset release: first cycles dark, then digits show 0 in scan order.
    step();
    check("first_an", 32'(an), 32'(4'b1111));
    check("first_seg", 32'(seg), 32'(7'h7F));
    for (int k = 0; k < 4; k++) begin
      run_until(8 * k + 5);
      check("idle_an", 32'(an), 32'(4'hF & ~(4'(1) << k)));
      check("idle_seg", 32'(seg), 32'(7'b1000000));
    end

    // Table vectors: load mid-frame, verify old value held, then new frame.
    for (int v = 0; v < 5; v++) begin
      run_until(10);
      do_load(vecs[v].data, vecs[v].dp, vecs[v].blank, 4'b0000);
      check("pending_rise", 32'(pending), 32'(1));
      run_until(0);
      check("pending_clear", 32'(pending), 32'(0));
      for (int k = 0; k < 4; k++) begin
        run_until(8 * k + 5);
        check("vec_an", 32'(an),
              32'(vecs[v].dark[k] ? 4'hF : (4'hF & ~(4'(1) << k))));
        check("vec_seg", 32'(seg), 32'(vecs[v].seg[k]));
        check("vec_dp", 32'(dp), 32'(vecs[v].dark[k] ? 1'b1 : vecs[v].dpo[k]));
      end
    end

    // Load on the boundary edge: display takes the pre-load shadow.
    run_until(10);
    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    run_until(FRAME - 1);
    do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
    check("bnd_pending", 32'(pending), 32'(1));
    run_until(5);
    check("bnd_old_seg", 32'(seg), 32'(7'b1111001));
    check("bnd_pending_hold", 32'(pending), 32'(1));
    run_until(0);
    check("bnd_pending_clr", 32'(pending), 32'(0));
    run_until(5);
    check("bnd_new_seg", 32'(seg), 32'(7'b0100100));
    run_until(12);
    do_load(16'h3333, 4'b0000, 4'b0000, 4'b0000);
    run_until(5);
    check("second_load_seg", 32'(seg), 32'(7'b0110000));

    // Blink on digit 0 across several blink periods.
    run_until(10);
    do_load(16'h0000, 4'b0000, 4'b0000, 4'b0001);
    for (int n = 0; n < 3 * BPERIOD; n++) step();

    // Reset with a pending value mid-dwell.
    run_until(12);
    do_load(16'h9999, 4'b1111, 4'b0000, 4'b0000);
    step();
    rst = 1'b1;
    step();
    check("rst_an", 32'(an), 32'(4'b1111));
    check("rst_pending", 32'(pending), 32'(0));
    rst = 1'b0;
    run_until(5);
    check("rst_restart_an", 32'(an), 32'(4'b1110));
    check("rst_restart_seg", 32'(seg), 32'(7'b1000000));
    for (int n = 0; n < FRAME; n++) step();

    // Randomized loads checked cycle by cycle against the model.
    for (int n = 0; n < 800; n++) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom) & 4'($urandom);
      blink_in = 4'($urandom);
      load     = ($urandom_range(0, 15) == 0);
      step();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
